mem_arbiter: RTL and testbench

//   Shares the single memory port between two masters: CPU (master 0, driven by cu mem_rd/mem_wr)
//   and DMA (master 1). Registered FSM grants one master per transaction, holds its command on the

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master memory port arbiter (CPU = master 0, DMA = master 1).
// Define MEM_ARBITER_RR_EN for round-robin; default is CPU priority with DMA anti-starvation.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_wr,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  grant_cpu;
    logic                  grant_dma;
    logic                  dma_wins;
    logic                  busy;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

`ifdef MEM_ARBITER_RR_EN
    // 1 = DMA was granted last; on a tie the other master wins
    logic last_gnt;

    assign dma_wins = ~last_gnt;

    // Remember the most recent winner for round-robin tie breaks
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (grant_cpu) begin
            last_gnt <= 1'b0;
        end else if (grant_dma) begin
            last_gnt <= 1'b1;
        end
    end
`else
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    assign dma_wins = (wait_cnt == MAX_W);

    // Count IDLE decisions lost by a waiting DMA; saturates at MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!dma_req || grant_dma) begin
            wait_cnt <= '0;
        end else if (grant_cpu && wait_cnt != MAX_W) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arbitration in IDLE, completion on mem_ready while busy
    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        unique case (state)
            IDLE: begin
                if (dma_req && (!cpu_req || dma_wins)) begin
                    grant_dma = 1'b1;
                    state_nx  = BUSY_DMA;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_nx  = BUSY_CPU;
                end
            end
            BUSY_CPU, BUSY_DMA: begin
                if (mem_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Memory port and grants follow the current owner; idle port reads as zero
    always_comb begin
        busy      = (state != IDLE);
        cpu_gnt   = (state == BUSY_CPU);
        dma_gnt   = (state == BUSY_DMA);
        mem_rd    = busy & ~wr_q;
        mem_wr    = busy & wr_q;
        mem_addr  = busy ? addr_q : '0;
        mem_wdata = busy ? wdata_q : '0;
    end

    // Latch the winner's command and return acks and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (grant_cpu) begin
                wr_q    <= cpu_wr;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end else if (grant_dma) begin
                wr_q    <= dma_wr;
                addr_q  <= dma_addr;
                wdata_q <= dma_wdata;
            end
            if (state == BUSY_CPU && mem_ready) begin
                cpu_ack <= 1'b1;
                if (!wr_q) begin
                    cpu_rdata <= mem_rdata;
                end
            end
            if (state == BUSY_DMA && mem_ready) begin
                dma_ack <= 1'b1;
                if (!wr_q) begin
                    dma_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an ack scoreboard.
// Honours MEM_ARBITER_RR_EN for the contention sequence.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_wr, dma_req, dma_wr;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata;
    logic          cpu_gnt, cpu_ack, dma_gnt, dma_ack;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_rdata;
    logic          mem_rd, mem_wr, mem_ready;

    typedef struct {
        logic        m;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   acks_cpu = 0;
    int   acks_dma = 0;
    int   push_cpu = 0;
    int   push_dma = 0;
    logic exp_m[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] d);
        exp_t e;
        e.m = m;
        e.d = d;
        sb.push_back(e);
        if (m) push_dma++;
        else push_cpu++;
    endtask

    task automatic take_ack(input logic m, input logic [31:0] d);
        exp_t e;
        if (m) acks_dma++;
        else acks_cpu++;
        if (sb.size() == 0) begin
            chk("unexpected_ack", {31'd0, m}, 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("ack_master", {31'd0, m}, {31'd0, e.m});
            chk("ack_rdata", d, e.d);
        end
    endtask

    // Advance one cycle and settle; score any ack seen in the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_ack) take_ack(1'b0, cpu_rdata);
        if (dma_ack) take_ack(1'b1, dma_rdata);
    endtask

    task automatic chk_idle_port(input string tag);
        chk({tag, "_gnt"}, {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        chk({tag, "_strb"}, {30'd0, mem_rd, mem_wr}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        tick();
        tick();
        // reset state
        chk_idle_port("rst");
        chk("rst_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_crdata", cpu_rdata, 32'd0);
        chk("rst_drdata", dma_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // 1: CPU read alone
        cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0010;
        push(1'b0, 32'hDEADBEEF);
        tick();
        chk("t1_rd", {31'd0, mem_rd}, 32'd1);
        chk("t1_wr", {31'd0, mem_wr}, 32'd0);
        chk("t1_addr", {16'd0, mem_addr}, 32'h0010);
        chk("t1_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd2);
        tick();
        chk("t1_hold", {31'd0, mem_rd}, 32'd1);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_ack", {31'd0, cpu_ack}, 32'd1);
        chk("t1_dack", {31'd0, dma_ack}, 32'd0);
        chk_idle_port("t1_done");
        cpu_req = 0; mem_ready = 0; mem_rdata = '0;
        tick();
        chk("t1_ackpulse", {31'd0, cpu_ack}, 32'd0);
        chk_idle_port("t1_after");

        // 2: DMA write, mem_ready on the 4th strobe cycle
        dma_req = 1; dma_wr = 1; dma_addr = 16'h0200;
        dma_wdata = 32'h12345678;
        push(1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_wr", {30'd0, mem_wr, mem_rd}, 32'd2);
            chk("t2_addr", {16'd0, mem_addr}, 32'h0200);
            chk("t2_wdata", mem_wdata, 32'h12345678);
            chk("t2_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd1);
            if (i == 3) begin
                mem_ready = 1;
                mem_rdata = 32'hBAD0BAD0;
            end
        end
        tick();
        chk("t2_ack", {31'd0, dma_ack}, 32'd1);
        chk("t2_rdata", dma_rdata, 32'h0);
        dma_req = 0; dma_wr = 0; mem_ready = 0; mem_rdata = '0;
        tick();
        chk("t2_ackpulse", {31'd0, dma_ack}, 32'd0);

        // 3: both requesting continuously, memory always ready
`ifdef MEM_ARBITER_RR_EN
        for (int k = 0; k < 18; k++) exp_m.push_back(k % 2 == 1);
`else
        begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < 18; k++) begin
                if (cnt == MW) begin
                    exp_m.push_back(1'b1);
                    cnt = 0;
                end else begin
                    exp_m.push_back(1'b0);
                    cnt++;
                end
            end
        end
`endif
        cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0030;
        dma_req = 1; dma_wr = 0; dma_addr = 16'h0300;
        mem_ready = 1; mem_rdata = 32'h0BADF00D;
        foreach (exp_m[k]) push(exp_m[k], 32'h0BADF00D);
        foreach (exp_m[k]) begin
            tick();
            chk($sformatf("t3_gnt%0d", k), {30'd0, cpu_gnt, dma_gnt},
                exp_m[k] ? 32'd1 : 32'd2);
            chk($sformatf("t3_addr%0d", k), {16'd0, mem_addr},
                exp_m[k] ? 32'h0300 : 32'h0030);
            tick();
        end
        cpu_req = 0; dma_req = 0; mem_ready = 0; mem_rdata = '0;
        tick();
        chk_idle_port("t3_after");

        // 4: CPU drops req after one busy cycle
        cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0044;
        push(1'b0, 32'h44556677);
        tick();
        chk("t4_gnt", {31'd0, cpu_gnt}, 32'd1);
        cpu_req = 0;
        tick();
        chk("t4_hold", {30'd0, cpu_gnt, mem_rd}, 32'd3);
        mem_ready = 1; mem_rdata = 32'h44556677;
        tick();
        chk("t4_ack", {31'd0, cpu_ack}, 32'd1);
        mem_ready = 0; mem_rdata = '0;
        tick();
        chk("t4_ackpulse", {31'd0, cpu_ack}, 32'd0);

        // 5: reset during a DMA transaction, CPU waiting
        dma_req = 1; dma_wr = 0; dma_addr = 16'h0500;
        tick();
        chk("t5_dgnt", {31'd0, dma_gnt}, 32'd1);
        tick();
        rst = 1; cpu_req = 1; cpu_addr = 16'h0055; dma_req = 0;
        tick();
        chk_idle_port("t5_rst");
        chk("t5_addr", {16'd0, mem_addr}, 32'd0);
        chk("t5_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("t5_crdata", cpu_rdata, 32'd0);
        rst = 0;
        tick();
        chk("t5_cgnt", {30'd0, cpu_gnt, dma_gnt}, 32'd2);
        chk("t5_caddr", {16'd0, mem_addr}, 32'h0055);
        push(1'b0, 32'h55AA55AA);
        mem_ready = 1; mem_rdata = 32'h55AA55AA;
        tick();
        chk("t5_cack", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 0; mem_ready = 0; mem_rdata = '0;
        tick();

        // 6: mem_ready while idle does nothing
        mem_ready = 1; mem_rdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_port("t6_idle");
            chk("t6_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        end
        mem_ready = 0;
        tick();

        chk("sb_empty", sb.size(), 32'd0);
        chk("cpu_acks", acks_cpu, push_cpu);
        chk("dma_acks", acks_dma, push_dma);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
